// File: rtl/odo_pkg.sv
// odo_pkg: shared widths, round limit and controller state encoding for the odo key-mixing blocks
package odo_pkg;
   localparam int KEY_W    = 10;
   localparam int PERIOD_W = 4;
   localparam logic [PERIOD_W-1:0] MAX_ROUNDS = 4'd10;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/odo_rotl1_xor.sv
// odo_rotl1_xor: one key-mixing round, rotate accumulator left by one then xor the round key
//   i_acc  current accumulator
//   i_key  round key
//   o_res  rotl1(i_acc) ^ i_key
module odo_rotl1_xor
   import odo_pkg::*;
(
   input  logic [KEY_W-1:0] i_acc,
   input  logic [KEY_W-1:0] i_key,
   output logic [KEY_W-1:0] o_res
);
   assign o_res = {i_acc[KEY_W-2:0], i_acc[KEY_W-1]} ^ i_key;
endmodule

// File: rtl/odo_round_key_seq.sv
// odo_round_key_seq: sequences N rounds of rotate-xor key mixing against an external registered key ROM
//   clk, rst_n  rising-edge clock, async active-low reset
//   start       run request, sampled only in IDLE when no done pulse is showing
//   state_in    initial accumulator, captured on acceptance
//   rounds      round count, captured on acceptance, clamped to MAX_ROUNDS
//   key         ROM key, valid one cycle after period is presented
//   period      round index driven to the ROM
//   busy        acceptance cycle+1 through the done cycle
//   done        one-cycle completion pulse
//   state_out   final accumulator, held until the next done
module odo_round_key_seq
   import odo_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [KEY_W-1:0]    state_in,
   input  logic [PERIOD_W-1:0] rounds,
   input  logic [KEY_W-1:0]    key,
   output logic [PERIOD_W-1:0] period,
   output logic                busy,
   output logic                done,
   output logic [KEY_W-1:0]    state_out
);
   state_t              r_state;
   state_t              w_state_nxt;
   logic [KEY_W-1:0]    r_acc;
   logic [KEY_W-1:0]    r_state_out;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_n;
   logic [1:0]          r_vld;
   logic                r_done;
   logic [PERIOD_W-1:0] w_n;
   logic [KEY_W-1:0]    w_next;
   logic                w_accept;

   assign w_n = (rounds > MAX_ROUNDS) ? MAX_ROUNDS : rounds;

   odo_rotl1_xor u_round (
      .i_acc (r_acc),
      .i_key (key),
      .o_res (w_next)
   );

   // start is ignored during the done cycle even though the FSM is already back in IDLE
   always_comb begin
      w_accept    = (r_state == IDLE) && start && !r_done;
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = (w_accept && w_n != '0) ? RUN : IDLE;
         RUN:     w_state_nxt = (r_cnt == r_n) ? DRAIN : RUN;
         DRAIN:   w_state_nxt = r_vld[1] ? IDLE : DRAIN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;

   // r_vld[0]: period register holds a live issue; r_vld[1]: key input holds its ROM result
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_acc       <= '0;
         r_state_out <= '0;
         r_period    <= '0;
         r_cnt       <= '0;
         r_n         <= '0;
         r_vld       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_vld[1] <= r_vld[0];
         if (r_vld[1]) r_acc <= w_next;
         if (w_accept) begin
            r_acc    <= state_in;
            r_n      <= w_n;
            r_period <= '0;
            r_cnt    <= 4'd1;
            r_vld[0] <= (w_n != '0);
            if (w_n == '0) begin
               r_done      <= 1'b1;
               r_state_out <= state_in;
            end
         end else if (r_state == RUN) begin
            if (r_cnt != r_n) begin
               r_period <= r_cnt;
               r_cnt    <= r_cnt + 4'd1;
            end else begin
               r_period <= '0;
               r_vld[0] <= 1'b0;
            end
         end else if (r_state == DRAIN && r_vld[1]) begin
            r_done      <= 1'b1;
            r_state_out <= w_next;
         end
      end

   assign period    = r_period;
   assign busy      = (r_state != IDLE) || r_done;
   assign done      = r_done;
   assign state_out = r_state_out;
endmodule

// File: tb/tb_odo_round_key_seq.sv
// tb_odo_round_key_seq: directed checks of odo_round_key_seq against a registered key ROM model
module tb_odo_round_key_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [9:0] state_in;
   logic [3:0] rounds;
   logic [9:0] key;
   logic [3:0] period;
   logic       busy;
   logic       done;
   logic [9:0] state_out;
   logic [9:0] rom [10];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   odo_round_key_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .state_in  (state_in),
      .rounds    (rounds),
      .key       (key),
      .period    (period),
      .busy      (busy),
      .done      (done),
      .state_out (state_out)
   );

   always_ff @(posedge clk) key <= (period < 4'd10) ? rom[period] : 10'h000;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model(input logic [9:0] s, input int n);
      logic [9:0] a = s;
      for (int i = 0; i < n; i++) a = {a[8:0], a[9]} ^ rom[i];
      return a;
   endfunction

   // called at a negedge; k counts the edge preceding each sample, E0 = acceptance edge
   task automatic do_pass(input logic [9:0] si, input logic [3:0] rn, input bit disturb,
                          output int done_k, output logic [9:0] res, output int busy_cnt,
                          output int busy_nd, output int done_cnt, output int per_err,
                          output int max_per);
      int n_eff = (rn > 4'd10) ? 10 : int'(rn);
      done_k = -1; res = 'x; busy_cnt = 0; busy_nd = 0; done_cnt = 0; per_err = 0; max_per = 0;
      start = 1'b1; state_in = si; rounds = rn;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (busy) busy_cnt++;
         if (busy && !done) busy_nd++;
         if (done) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k = k;
               res = state_out;
            end
         end
         if (int'(period) > max_per) max_per = int'(period);
         if (int'(period) !== ((k < n_eff) ? k : 0)) per_err++;
         if (disturb) begin
            start    = (k >= 1) && (done_k < 0 || k == done_k);
            state_in = 10'h3ff;
            rounds   = 4'd1;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int dk, bc, bnd, dc, pe, mp, dcount;
      logic [9:0] r;
      rom[0] = 10'h10e; rom[1] = 10'h0c1; rom[2] = 10'h120; rom[3] = 10'h21d; rom[4] = 10'h3a5;
      rom[5] = 10'h07f; rom[6] = 10'h2c3; rom[7] = 10'h111; rom[8] = 10'h0aa; rom[9] = 10'h356;
      rst_n = 1'b0; start = 1'b0; state_in = '0; rounds = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_period", period, 0);
      chk("rst_state_out", state_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_pass(10'h000, 4'd1, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("n1_done_k", dk, 2);
      chk("n1_result", r, 10'h10e);
      chk("n1_done_cnt", dc, 1);
      chk("n1_period", pe, 0);
      chk("n1_busy", bc, 3);

      do_pass(10'h000, 4'd2, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("n2_done_k", dk, 3);
      chk("n2_result", r, 10'h2dd);
      chk("n2_busy_before_done", bnd, 3);
      chk("n2_period", pe, 0);

      do_pass(10'h155, 4'd0, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("n0_done_k", dk, 0);
      chk("n0_result", r, 10'h155);
      chk("n0_period", pe, 0);
      chk("n0_busy", bc, 1);

      do_pass(10'h000, 4'd4, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("n4_done_k", dk, 5);
      chk("n4_result", r, 10'h32b);

      do_pass(10'h2a7, 4'd15, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("n15_done_k", dk, 11);
      chk("n15_max_period", mp, 9);
      chk("n15_period", pe, 0);
      chk("n15_result", r, model(10'h2a7, 10));

      do_pass(10'h0f3, 4'd5, 1'b1, dk, r, bc, bnd, dc, pe, mp);
      chk("dist_result", r, model(10'h0f3, 5));
      chk("dist_done_cnt", dc, 1);
      chk("dist_busy", bc, 7);
      chk("dist_done_k", dk, 6);

      start = 1'b1; state_in = 10'h1c7; rounds = 4'd8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_state_out", state_out, 0);
      chk("abort_done", done, 0);
      chk("abort_period", period, 0);
      dcount = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("abort_no_done", dcount, 0);

      do_pass(10'h000, 4'd3, 1'b0, dk, r, bc, bnd, dc, pe, mp);
      chk("post_rst_result", r, 10'h09b);
      chk("post_rst_done_k", dk, 4);
      chk("post_rst_period", pe, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
